// File: rtl/game_pkg.sv
// Shared types, constants and helpers for the 2048 grid controller.
package game_pkg;
    localparam int          CELL_W    = 4;
    localparam int          GRID_N    = 4;
    localparam int          PTS_W     = 17;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef logic [CELL_W-1:0] cell_t;
    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
    typedef enum logic [1:0] {IDLE, SLIDE, SPAWN, DONE} state_t;

    // Points earned for producing a tile with the given log2 code.
    function automatic logic [PTS_W-1:0] code_points(input cell_t code);
        return PTS_W'(1) << code;
    endfunction
endpackage

// File: rtl/grid_line_merge.sv
// Slides and merges one 4-cell line toward element 0; reports points and change.
// Latency: combinational.
// Backpressure: none; the caller presents one line per cycle.
module grid_line_merge
    import game_pkg::*;
(
    input  cell_t [GRID_N-1:0] line_in,
    output cell_t [GRID_N-1:0] line_out,
    output logic  [PTS_W-1:0]  pts,
    output logic               changed
);
    cell_t [GRID_N:0] comp;   // extra zero slot keeps comp[i+1] in range
    logic  [2:0]      n_comp;
    logic  [2:0]      n_out;
    logic             skip;

    always_comb begin
        comp     = '0;
        n_comp   = '0;
        line_out = '0;
        n_out    = '0;
        skip     = 1'b0;
        pts      = '0;
        for (int i = 0; i < GRID_N; i++) begin
            if (line_in[i] != '0) begin
                comp[n_comp] = line_in[i];
                n_comp       = n_comp + 3'd1;
            end
        end
        // A merged tile consumes its partner, so it cannot merge again this move.
        for (int i = 0; i < GRID_N; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[i] != '0) begin
                if (comp[i] == comp[i+1] && comp[i] != '1) begin
                    line_out[n_out[1:0]] = comp[i] + cell_t'(1);
                    pts                  = pts + code_points(comp[i] + cell_t'(1));
                    skip                 = 1'b1;
                end else begin
                    line_out[n_out[1:0]] = comp[i];
                end
                n_out = n_out + 3'd1;
            end
        end
        changed = (line_out != line_in);
    end
endmodule

// File: rtl/grid_move_controller.sv
// Owns the 4x4 2048 grid: edge-detected moves, line slide/merge, random spawn, win/over.
// Latency: press at T -> busy from T+1; move_done at T+5 without change, plus 1..16 per spawned tile.
// Backpressure: direction/new presses arriving while busy are dropped; ld_en only honoured in IDLE.
module grid_move_controller
    import game_pkg::*;
#(
    parameter int          WIN_EXP   = 11,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          SCORE_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_new,
    input  logic [1:0]         rd_x,
    input  logic [1:0]         rd_y,
    output logic [3:0]         rd_val,
    input  logic               ld_en,
    input  logic [1:0]         ld_x,
    input  logic [1:0]         ld_y,
    input  logic [3:0]         ld_val,
    output logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic               move_done,
    output logic               moved,
    output logic               won,
    output logic               game_over
);
    localparam int SUM_W = ((SCORE_W > PTS_W) ? SCORE_W : PTS_W) + 1;

    state_t      state, state_nxt;
    cell_t       grid [GRID_N][GRID_N];   // grid[x][y]
    logic [15:0] lfsr, lfsr_nxt;
    logic        init_pending;
    logic [4:0]  btn_now, btn_prev, press;  // {new, right, left, down, up}
    dir_t        dir, dir_sel;
    logic [1:0]  line_idx;
    logic        changed;
    logic [1:0]  spawn_left;
    logic [3:0]  scan_idx;
    logic [3:0]  scan_cnt;

    logic [1:0]          ex [GRID_N];
    logic [1:0]          ey [GRID_N];
    cell_t [GRID_N-1:0]  line_in, line_out;
    logic [PTS_W-1:0]    line_pts;
    logic                line_chg;
    logic [SUM_W-1:0]    score_sum;
    logic [SCORE_W-1:0]  score_sat;
    cell_t               spawn_cell, spawn_val;
    logic                any_empty, any_pair, any_win;
    logic                start_game, do_load, start_move;

    assign btn_now   = {btn_new, btn_right, btn_left, btn_down, btn_up};
    assign press     = btn_now & ~btn_prev;
    assign lfsr_nxt  = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
    assign rd_val    = grid[rd_x][rd_y];
    assign busy      = (state != IDLE);
    assign move_done = (state == DONE);
    assign moved     = (state == DONE) && changed;

    // Element 0 of each line is the edge the tiles travel toward.
    always_comb begin
        for (int e = 0; e < GRID_N; e++) begin
            ex[e] = '0;
            ey[e] = '0;
            case (dir)
                UP:      begin ex[e] = line_idx;              ey[e] = 2'(e);              end
                DOWN:    begin ex[e] = line_idx;              ey[e] = 2'(GRID_N - 1 - e); end
                LEFT:    begin ex[e] = 2'(e);                 ey[e] = line_idx;           end
                default: begin ex[e] = 2'(GRID_N - 1 - e);    ey[e] = line_idx;           end
            endcase
            line_in[e] = grid[ex[e]][ey[e]];
        end
    end

    grid_line_merge u_merge (
        .line_in  (line_in),
        .line_out (line_out),
        .pts      (line_pts),
        .changed  (line_chg)
    );

    assign score_sum = SUM_W'(score) + SUM_W'(line_pts);
    assign score_sat = (score_sum > SUM_W'({SCORE_W{1'b1}})) ? '1 : score_sum[SCORE_W-1:0];

    assign spawn_cell = grid[scan_idx[1:0]][scan_idx[3:2]];
    assign spawn_val  = (lfsr[7:4] == 4'd0) ? cell_t'(2) : cell_t'(1);

    always_comb begin
        any_empty = 1'b0;
        any_pair  = 1'b0;
        any_win   = 1'b0;
        for (int x = 0; x < GRID_N; x++) begin
            for (int y = 0; y < GRID_N; y++) begin
                if (grid[x][y] == '0)                any_empty = 1'b1;
                if (grid[x][y] >= cell_t'(WIN_EXP)) any_win   = 1'b1;
            end
        end
        for (int x = 0; x < GRID_N - 1; x++)
            for (int y = 0; y < GRID_N; y++)
                if (grid[x][y] == grid[x+1][y]) any_pair = 1'b1;
        for (int x = 0; x < GRID_N; x++)
            for (int y = 0; y < GRID_N - 1; y++)
                if (grid[x][y] == grid[x][y+1]) any_pair = 1'b1;
    end

    always_comb begin
        state_nxt  = state;
        start_game = 1'b0;
        do_load    = 1'b0;
        start_move = 1'b0;
        if (press[0])      dir_sel = UP;
        else if (press[1]) dir_sel = DOWN;
        else if (press[2]) dir_sel = LEFT;
        else               dir_sel = RIGHT;
        case (state)
            IDLE: begin
                if (init_pending || press[4]) begin
                    start_game = 1'b1;
                    state_nxt  = SPAWN;
                end else if (ld_en) begin
                    do_load = 1'b1;
                end else if ((|press[3:0]) && !game_over) begin
                    start_move = 1'b1;
                    state_nxt  = SLIDE;
                end
            end
            SLIDE: begin
                if (line_idx == 2'd3) state_nxt = (changed || line_chg) ? SPAWN : DONE;
            end
            SPAWN: begin
                if (spawn_cell == '0) begin
                    if (spawn_left == 2'd1) state_nxt = DONE;
                end else if (scan_cnt == 4'd15) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int x = 0; x < GRID_N; x++)
                for (int y = 0; y < GRID_N; y++)
                    grid[x][y] <= '0;
            score        <= '0;
            won          <= 1'b0;
            game_over    <= 1'b0;
            lfsr         <= LFSR_SEED;
            init_pending <= 1'b1;
            btn_prev     <= '0;
            dir          <= UP;
            line_idx     <= '0;
            changed      <= 1'b0;
            spawn_left   <= '0;
            scan_idx     <= '0;
            scan_cnt     <= '0;
        end else begin
            lfsr     <= lfsr_nxt;
            btn_prev <= btn_now;
            case (state)
                IDLE: begin
                    if (start_game) begin
                        for (int x = 0; x < GRID_N; x++)
                            for (int y = 0; y < GRID_N; y++)
                                grid[x][y] <= '0;
                        score        <= '0;
                        won          <= 1'b0;
                        game_over    <= 1'b0;
                        init_pending <= 1'b0;
                        changed      <= 1'b0;
                        spawn_left   <= 2'd2;
                        scan_idx     <= lfsr[3:0];
                        scan_cnt     <= '0;
                    end else if (do_load) begin
                        grid[ld_x][ld_y] <= ld_val;
                    end else if (start_move) begin
                        dir      <= dir_sel;
                        line_idx <= '0;
                        changed  <= 1'b0;
                    end
                end
                SLIDE: begin
                    for (int e = 0; e < GRID_N; e++)
                        grid[ex[e]][ey[e]] <= line_out[e];
                    score    <= score_sat;
                    changed  <= changed | line_chg;
                    line_idx <= line_idx + 2'd1;
                    if (line_idx == 2'd3) begin
                        spawn_left <= 2'd1;
                        scan_idx   <= lfsr[3:0];
                        scan_cnt   <= '0;
                    end
                end
                SPAWN: begin
                    if (spawn_cell == '0) begin
                        grid[scan_idx[1:0]][scan_idx[3:2]] <= spawn_val;
                        spawn_left <= spawn_left - 2'd1;
                        scan_idx   <= lfsr[3:0];
                        scan_cnt   <= '0;
                    end else begin
                        scan_idx <= scan_idx + 4'd1;
                        scan_cnt <= scan_cnt + 4'd1;
                    end
                end
                DONE: begin
                    game_over <= ~any_empty & ~any_pair;
                    won       <= won | any_win;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_grid_move_controller.sv
// Directed bench for grid_move_controller: loads boards, issues moves, checks grid/score/flags.
module tb_grid_move_controller;
    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_UP    = 5'b00001;
    localparam logic [4:0] B_LEFT  = 5'b00100;
    localparam logic [4:0] B_RIGHT = 5'b01000;
    localparam logic [4:0] B_NEW   = 5'b10000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_new = 1'b0;
    logic [1:0]  rd_x = '0, rd_y = '0, ld_x = '0, ld_y = '0;
    logic [3:0]  rd_val;
    logic [3:0]  ld_val = '0;
    logic        ld_en = 1'b0;
    logic [15:0] score;
    logic        busy, move_done, moved, won, game_over;

    int         checks = 0;
    int         errors = 0;
    int         exp_score = 0;
    logic [3:0] g [4][4];

    always #5 clk = ~clk;

    grid_move_controller #(.WIN_EXP(11), .LFSR_SEED(16'hACE1), .SCORE_W(16)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_new(btn_new),
        .rd_x(rd_x), .rd_y(rd_y), .rd_val(rd_val),
        .ld_en(ld_en), .ld_x(ld_x), .ld_y(ld_y), .ld_val(ld_val),
        .score(score), .busy(busy), .move_done(move_done), .moved(moved),
        .won(won), .game_over(game_over)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_btns(input logic [4:0] b);
        {btn_new, btn_right, btn_left, btn_down, btn_up} = b;
    endtask

    task automatic load_cell(input int x, input int y, input int v);
        ld_x = 2'(x); ld_y = 2'(y); ld_val = 4'(v); ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic clear_grid;
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                load_cell(x, y, 0);
    endtask

    // Presses b for one cycle and waits (bounded) for move_done; cyc = -1 on timeout.
    task automatic run_move(input logic [4:0] b, output int cyc, output logic mv, output logic busy1);
        int i;
        cyc = -1; mv = 1'b0; busy1 = 1'b0; i = 0;
        set_btns(b);
        while (cyc < 0 && i < 60) begin
            @(negedge clk);
            i++;
            if (i == 1) begin
                busy1 = busy;
                set_btns(B_NONE);
            end
            if (move_done === 1'b1) begin
                cyc = i;
                mv  = moved;
            end
        end
        @(negedge clk);
    endtask

    task automatic snap_grid;
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++) begin
                rd_x = 2'(x); rd_y = 2'(y);
                #1;
                g[x][y] = rd_val;
            end
        @(negedge clk);
    endtask

    // Counts nonzero cells of g outside two excluded coordinates; flags any value not 1 or 2.
    function automatic int count_nz(input int ax, input int ay, input int bx, input int by,
                                    output bit vals_ok);
        int n = 0;
        vals_ok = 1'b1;
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                if (!((x == ax && y == ay) || (x == bx && y == by)) && g[x][y] != 4'd0) begin
                    n++;
                    if (g[x][y] != 4'd1 && g[x][y] != 4'd2) vals_ok = 1'b0;
                end
        return n;
    endfunction

    task automatic test_reset;
        int cyc, n; logic mv, b1; bit ok;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
        checks++; if ({busy, move_done, moved, won, game_over} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {busy, move_done, moved, won, game_over}); end
        snap_grid();
        n = count_nz(-1, -1, -1, -1, ok);
        checks++; if (n !== 0) begin errors++; $display("FAIL reset_grid: got %0d nonzero want 0", n); end
        reset = 1'b0;
        run_move(B_NONE, cyc, mv, b1);
        checks++; if (cyc < 3 || cyc > 34) begin errors++; $display("FAIL init_done_latency: got %0d want 3..34", cyc); end
        checks++; if (mv !== 1'b0) begin errors++; $display("FAIL init_moved: got %b want 0", mv); end
        snap_grid();
        n = count_nz(-1, -1, -1, -1, ok);
        checks++; if (n !== 2 || !ok) begin errors++; $display("FAIL init_tiles: got %0d tiles ok=%0d want 2 ok=1", n, ok); end
        exp_score = 0;
    endtask

    task automatic test_merge_left;
        int cyc, n; logic mv, b1; bit ok;
        clear_grid();
        load_cell(0, 0, 1); load_cell(1, 0, 1); load_cell(2, 0, 2); load_cell(3, 0, 2);
        run_move(B_LEFT, cyc, mv, b1);
        exp_score += 12;
        snap_grid();
        checks++; if (g[0][0] !== 4'd2 || g[1][0] !== 4'd3) begin
            errors++; $display("FAIL merge_left_row: got %0d,%0d want 2,3", g[0][0], g[1][0]); end
        checks++; if (score !== 16'(exp_score)) begin errors++; $display("FAIL merge_left_score: got %0d want %0d", score, exp_score); end
        checks++; if (mv !== 1'b1 || cyc < 6 || cyc > 21) begin
            errors++; $display("FAIL merge_left_done: moved=%b cyc=%0d want 1, 6..21", mv, cyc); end
        n = count_nz(0, 0, 1, 0, ok);
        checks++; if (n !== 1 || !ok) begin errors++; $display("FAIL merge_left_spawn: got %0d ok=%0d want 1 ok=1", n, ok); end
    endtask

    task automatic test_no_triple;
        int cyc, n; logic mv, b1; bit ok;
        clear_grid();
        for (int x = 0; x < 4; x++) load_cell(x, 0, 1);
        run_move(B_RIGHT, cyc, mv, b1);
        exp_score += 8;
        snap_grid();
        checks++; if (g[2][0] !== 4'd2 || g[3][0] !== 4'd2) begin
            errors++; $display("FAIL right_row: got x2=%0d x3=%0d want 2,2", g[2][0], g[3][0]); end
        checks++; if (score !== 16'(exp_score)) begin errors++; $display("FAIL right_score: got %0d want %0d", score, exp_score); end
        n = count_nz(2, 0, 3, 0, ok);
        checks++; if (n !== 1 || !ok) begin errors++; $display("FAIL right_spawn: got %0d ok=%0d want 1 ok=1", n, ok); end
    endtask

    task automatic test_no_move;
        int cyc, bad; logic mv, b1;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) load_cell(x, y, x + 1);
        run_move(B_LEFT, cyc, mv, b1);
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL nomove_busy: got %b want 1", b1); end
        checks++; if (cyc !== 5) begin errors++; $display("FAIL nomove_latency: got %0d want 5", cyc); end
        checks++; if (mv !== 1'b0) begin errors++; $display("FAIL nomove_moved: got %b want 0", mv); end
        snap_grid();
        bad = 0;
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                if (g[x][y] != 4'(x + 1)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL nomove_grid: got %0d changed cells want 0", bad); end
        checks++; if (score !== 16'(exp_score)) begin errors++; $display("FAIL nomove_score: got %0d want %0d", score, exp_score); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL nomove_over: got %b want 0", game_over); end
    endtask

    task automatic test_game_over;
        int cyc, n, bad; logic mv, b1; bit ok;
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++) load_cell(x, y, ((x + y) % 2 == 1) ? 2 : 1);
        run_move(B_UP, cyc, mv, b1);
        checks++; if (mv !== 1'b0 || cyc !== 5) begin errors++; $display("FAIL over_move: moved=%b cyc=%0d want 0,5", mv, cyc); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL over_flag: got %b want 1", game_over); end
        bad = 0;
        set_btns(B_LEFT);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_btns(B_NONE);
            if (busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL over_ignore: busy seen %0d cycles want 0", bad); end
        run_move(B_NEW, cyc, mv, b1);
        exp_score = 0;
        checks++; if (cyc < 3 || cyc > 34 || mv !== 1'b0) begin
            errors++; $display("FAIL new_done: cyc=%0d moved=%b want 3..34, 0", cyc, mv); end
        snap_grid();
        n = count_nz(-1, -1, -1, -1, ok);
        checks++; if (n !== 2 || !ok) begin errors++; $display("FAIL new_tiles: got %0d ok=%0d want 2 ok=1", n, ok); end
        checks++; if (score !== 16'd0 || game_over !== 1'b0) begin
            errors++; $display("FAIL new_state: score=%0d over=%b want 0,0", score, game_over); end
    endtask

    task automatic test_win;
        int cyc; logic mv, b1;
        clear_grid();
        load_cell(0, 0, 10); load_cell(1, 0, 10);
        run_move(B_LEFT, cyc, mv, b1);
        exp_score += 2048;
        snap_grid();
        checks++; if (g[0][0] !== 4'd11) begin errors++; $display("FAIL win_cell: got %0d want 11", g[0][0]); end
        checks++; if (won !== 1'b1) begin errors++; $display("FAIL win_flag: got %b want 1", won); end
        checks++; if (score !== 16'(exp_score)) begin errors++; $display("FAIL win_score: got %0d want %0d", score, exp_score); end
    endtask

    task automatic test_priority;
        int cyc; logic mv, b1;
        clear_grid();
        load_cell(1, 1, 3);
        run_move(B_UP | B_LEFT, cyc, mv, b1);
        snap_grid();
        checks++; if (g[1][0] !== 4'd3 || g[0][1] === 4'd3) begin
            errors++; $display("FAIL priority_up: got (1,0)=%0d (0,1)=%0d want 3, not 3", g[1][0], g[0][1]); end
        checks++; if (score !== 16'(exp_score)) begin errors++; $display("FAIL priority_score: got %0d want %0d", score, exp_score); end
    endtask

    task automatic test_hold;
        int pulses;
        clear_grid();
        load_cell(3, 0, 1);
        pulses = 0;
        set_btns(B_LEFT);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (move_done === 1'b1) pulses++;
        end
        set_btns(B_NONE);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (move_done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_moves: got %0d want 1", pulses); end
        snap_grid();
        checks++; if (g[0][0] !== 4'd1) begin errors++; $display("FAIL hold_cell: got %0d want 1", g[0][0]); end
    endtask

    task automatic test_back_to_back;
        int pulses;
        clear_grid();
        load_cell(3, 3, 1);
        pulses = 0;
        set_btns(B_LEFT);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) set_btns(B_NONE);
            if (i == 2) set_btns(B_RIGHT);
            if (i == 3) set_btns(B_NONE);
            if (move_done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_press_moves: got %0d want 1", pulses); end
        snap_grid();
        checks++; if (g[0][3] !== 4'd1) begin errors++; $display("FAIL busy_press_cell: got %0d want 1", g[0][3]); end
    endtask

    task automatic test_reset_mid_move;
        int cyc, n; logic mv, b1; bit ok;
        clear_grid();
        load_cell(3, 0, 1);
        set_btns(B_LEFT);
        @(negedge clk);
        set_btns(B_NONE);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        exp_score = 0;
        checks++; if ({busy, move_done, moved, won, game_over} !== 5'b0 || score !== 16'd0) begin
            errors++; $display("FAIL midreset_outputs: flags=%b score=%0d want 00000,0",
                               {busy, move_done, moved, won, game_over}, score); end
        snap_grid();
        n = count_nz(-1, -1, -1, -1, ok);
        checks++; if (n !== 0) begin errors++; $display("FAIL midreset_grid: got %0d nonzero want 0", n); end
        reset = 1'b0;
        run_move(B_NONE, cyc, mv, b1);
        snap_grid();
        n = count_nz(-1, -1, -1, -1, ok);
        checks++; if (cyc < 3 || n !== 2 || !ok) begin
            errors++; $display("FAIL midreset_respawn: cyc=%0d tiles=%0d ok=%0d want >=3,2,1", cyc, n, ok); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_merge_left();
        test_no_triple();
        test_no_move();
        test_game_over();
        test_win();
        test_priority();
        test_hold();
        test_back_to_back();
        test_reset_mid_move();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
